// File: rtl/btb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : btb_pkg                                                |
// | Description : Shared types, geometry and PC field extraction for the |
// |               2-way set-associative branch target buffer.            |
// | Options     : BTB_BYPASS_EN (used by branch_target_buffer)           |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package btb_pkg;

   // Storage geometry; the top-level NUM_SETS / XLEN defaults come from here
   localparam int BTB_NUM_SETS = 32;
   localparam int BTB_XLEN     = 32;
   localparam int IDX_W        = $clog2(BTB_NUM_SETS);
   localparam int TAG_W        = BTB_XLEN - IDX_W - 2;

   typedef struct packed {
      logic                valid;
      logic [TAG_W-1:0]    tag;
      logic [BTB_XLEN-3:0] target;   // word-aligned target, bits [XLEN-1:2]
      logic                is_jump;
   } btb_entry_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } btb_state_e;

   function automatic logic [IDX_W-1:0] pc_idx(input logic [BTB_XLEN-1:0] pc);
      return pc[IDX_W+1:2];
   endfunction

   function automatic logic [TAG_W-1:0] pc_tag(input logic [BTB_XLEN-1:0] pc);
      return pc[BTB_XLEN-1:IDX_W+2];
   endfunction

endpackage
`default_nettype wire

// File: rtl/btb_set_way_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : btb_set_way_select                                     |
// | Description : Way selection for one 2-way set: hit detection with    |
// |               way-0 priority and victim choice (first invalid way,   |
// |               otherwise the LRU way).                                |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module btb_set_way_select (
   input  logic [1:0] valid,
   input  logic [1:0] match,
   input  logic       lru,
   output logic       hit,
   output logic       hit_way,
   output logic       victim_way
);

   logic [1:0] way_hit;

   assign way_hit    = valid & match;
   assign hit        = |way_hit;
   // way 0 wins when both ways match
   assign hit_way    = ~way_hit[0];
   // fill empty ways before evicting anything
   assign victim_way = ~valid[0] ? 1'b0 :
                       ~valid[1] ? 1'b1 : lru;

endmodule
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : branch_target_buffer                                   |
// | Description : 2-way set-associative BTB. Zero-latency lookup from    |
// |               the IF PC, allocation/update from EX resolution, and a |
// |               NUM_SETS-cycle invalidate-all sweep on flush_req.      |
// | Options     : BTB_BYPASS_EN - forward a same-cycle update to lookup  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module branch_target_buffer
   import btb_pkg::*;
#(
   // storage geometry is taken from btb_pkg; overrides must agree with it
   parameter int NUM_SETS = BTB_NUM_SETS,
   parameter int XLEN     = BTB_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_if,
   output logic            btb_hit,
   output logic [XLEN-1:0] btb_target,
   output logic            btb_is_jump,
   input  logic            is_branch_ex,
   input  logic            is_jump_ex,
   input  logic [XLEN-1:0] pc_ex,
   input  logic [XLEN-1:0] branch_pc_ex,
   input  logic            cmp_out_ex,
   input  logic            flush_req,
   output logic            btb_busy
);

   btb_entry_t          mem [NUM_SETS][2];
   logic [NUM_SETS-1:0] lru;
   btb_state_e          state_q;
   btb_state_e          state_d;
   logic [IDX_W-1:0]    cnt_q;
   logic [IDX_W-1:0]    cnt_d;

   logic [IDX_W-1:0]    l_idx;
   logic [TAG_W-1:0]    l_tag;
   logic [IDX_W-1:0]    u_idx;
   logic [TAG_W-1:0]    u_tag;
   logic [1:0]          l_valid;
   logic [1:0]          l_match;
   logic [1:0]          u_valid;
   logic [1:0]          u_match;
   logic                l_hit;
   logic                l_way;
   logic                u_hit;
   logic                u_way;
   logic                u_victim;
   logic                wr_way;
   logic                upd_ok;
   btb_entry_t          new_entry;
   logic                unused_l_victim;
   logic                unused_bits;

   assign l_idx = pc_idx(pc_if);
   assign l_tag = pc_tag(pc_if);
   assign u_idx = pc_idx(pc_ex);
   assign u_tag = pc_tag(pc_ex);

   for (genvar w = 0; w < 2; w++) begin : g_way
      assign l_valid[w] = mem[l_idx][w].valid;
      assign l_match[w] = (mem[l_idx][w].tag == l_tag);
      assign u_valid[w] = mem[u_idx][w].valid;
      assign u_match[w] = (mem[u_idx][w].tag == u_tag);
   end

   btb_set_way_select u_lookup_sel (
      .valid      (l_valid),
      .match      (l_match),
      .lru        (lru[l_idx]),
      .hit        (l_hit),
      .hit_way    (l_way),
      .victim_way (unused_l_victim)
   );

   btb_set_way_select u_update_sel (
      .valid      (u_valid),
      .match      (u_match),
      .lru        (lru[u_idx]),
      .hit        (u_hit),
      .hit_way    (u_way),
      .victim_way (u_victim)
   );

   // only taken branches and jumps touch the array, and never during a sweep or flush
   assign upd_ok    = ((is_branch_ex & cmp_out_ex) | is_jump_ex) &
                      (state_q == IDLE) & ~flush_req;
   assign wr_way    = u_hit ? u_way : u_victim;
   assign new_entry = '{valid: 1'b1, tag: u_tag,
                        target: branch_pc_ex[XLEN-1:2], is_jump: is_jump_ex};
   assign btb_busy  = (state_q == CLEAR);

   // low address bits never reach storage
   assign unused_bits = ^{branch_pc_ex[1:0]};

   // sweep state and set counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // sweep sequencing: one set per cycle, flush_req ignored once started
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (flush_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(NUM_SETS - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // entry array and per-set LRU: sweep invalidation or EX-driven install/rewrite
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            mem[s][0] <= '0;
            mem[s][1] <= '0;
         end
         lru <= '0;
      end else if (state_q == CLEAR) begin
         mem[cnt_q][0].valid <= 1'b0;
         mem[cnt_q][1].valid <= 1'b0;
         lru[cnt_q]          <= 1'b0;
      end else if (upd_ok) begin
         mem[u_idx][wr_way] <= new_entry;
         lru[u_idx]         <= ~wr_way;
      end
   end

   // lookup outputs, zeroed on a miss or while sweeping
   always_comb begin
      btb_hit     = 1'b0;
      btb_target  = '0;
      btb_is_jump = 1'b0;
      if (!btb_busy) begin
         if (l_hit) begin
            btb_hit     = 1'b1;
            btb_target  = {mem[l_idx][l_way].target, 2'b00};
            btb_is_jump = mem[l_idx][l_way].is_jump;
         end
`ifdef BTB_BYPASS_EN
         if (upd_ok && (u_idx == l_idx) && (u_tag == l_tag)) begin
            btb_hit     = 1'b1;
            btb_target  = {branch_pc_ex[XLEN-1:2], 2'b00};
            btb_is_jump = is_jump_ex;
         end
`else
`endif
      end
   end

endmodule
`default_nettype wire
